cache_bus_mem_slave: RTL



---
 rtl/cache_bus_mem_slave_if.sv | 73 +++++++
 rtl/cache_bus_mem_slave.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_mem_slave_if.sv
// rtl/cache_bus_mem_slave_if.sv - CacheBus channel bundle with master and slave modports
interface CacheBus #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]       aw_id;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic [3:0]                aw_snoop;
    logic [USER_WIDTH-1:0]     aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      w_ready;

    logic [ID_WIDTH-1:0]       b_id;
    logic [1:0]                b_resp;
    logic [USER_WIDTH-1:0]     b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [ID_WIDTH-1:0]       ar_id;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic [3:0]                ar_snoop;
    logic [USER_WIDTH-1:0]     ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [ID_WIDTH-1:0]       r_id;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [4:0]                r_resp;
    logic                      r_last;
    logic [USER_WIDTH-1:0]     r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_snoop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_snoop, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_snoop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_snoop, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/cache_bus_mem_slave.sv
// rtl/cache_bus_mem_slave.sv - CacheBus memory responder with independent read and write burst FSMs
module cache_bus_mem_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    USER_WIDTH = 1,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic     clk,
    input  logic     rst_n,
    CacheBus.slave   bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF        = $clog2(STRB_WIDTH);
    localparam int IDXW       = $clog2(DEPTH);
    localparam int AW1        = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] LIMIT = {1'b0, BASE_ADDR} + AW1'(DEPTH * STRB_WIDTH);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0]            len,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_WIDTH'(STRB_WIDTH);
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << OFF) - ADDR_WIDTH'(1);
        case (burst)
            2'd0:    return a;
            2'd2:    return (a & ~mask) | ((a + step) & mask);
            default: return a + step;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- read channel ----------------
    typedef enum logic {R_IDLE, R_BURST} r_state_t;

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [USER_WIDTH-1:0] r_user_q;
    logic                  r_ok;
    logic                  r_busy;

    assign r_busy = (r_state == R_BURST);
    assign r_ok   = in_range(r_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_id_q   <= '0;
            r_user_q <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.ar_valid) begin
                        r_addr   <= bus.ar_addr;
                        r_len    <= bus.ar_len;
                        r_burst  <= bus.ar_burst;
                        r_id_q   <= bus.ar_id;
                        r_user_q <= bus.ar_user;
                        r_cnt    <= '0;
                        r_state  <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (bus.r_ready) begin
                        r_addr <= next_addr(r_addr, r_len, r_burst);
                        r_cnt  <= r_cnt + 8'd1;
                        if (r_cnt == r_len) r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Read data comes straight off the array so a same-cycle write is seen one cycle later.
    assign bus.ar_ready = rst_n && (r_state == R_IDLE);
    assign bus.r_valid  = r_busy;
    assign bus.r_last   = r_busy && (r_cnt == r_len);
    assign bus.r_data   = (r_busy && r_ok) ? mem[r_addr[OFF +: IDXW]] : '0;
    assign bus.r_resp   = {3'b001, (r_busy && !r_ok) ? 2'b10 : 2'b00};
    assign bus.r_id     = r_id_q;
    assign bus.r_user   = r_user_q;

    // ---------------- write channel ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [1:0]            w_burst;
    logic [8:0]            w_cnt;
    logic                  w_err;
    logic [ID_WIDTH-1:0]   b_id_q;
    logic [USER_WIDTH-1:0] b_user_q;
    logic                  w_fire;
    logic                  w_ok;
    logic                  w_in_len;
    logic                  mem_we;

    assign w_fire   = (w_state == W_DATA) && bus.w_valid;
    assign w_ok     = in_range(w_addr);
    assign w_in_len = (w_cnt <= {1'b0, w_len});
    assign mem_we   = w_fire && w_ok && w_in_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            w_addr   <= '0;
            w_len    <= '0;
            w_burst  <= '0;
            w_cnt    <= '0;
            w_err    <= 1'b0;
            b_id_q   <= '0;
            b_user_q <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (bus.aw_valid) begin
                        w_addr   <= bus.aw_addr;
                        w_len    <= bus.aw_len;
                        w_burst  <= bus.aw_burst;
                        b_id_q   <= bus.aw_id;
                        b_user_q <= bus.aw_user;
                        w_cnt    <= '0;
                        w_err    <= 1'b0;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (!w_ok) w_err <= 1'b1;
                        // Counter parks at len+1 so overlong bursts keep being dropped.
                        if (w_in_len) begin
                            w_cnt  <= w_cnt + 9'd1;
                            w_addr <= next_addr(w_addr, w_len, w_burst);
                        end
                        if (bus.w_last) begin
                            w_state <= W_RESP;
                            if (w_cnt != {1'b0, w_len}) w_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.b_ready) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (bus.w_strb[i]) mem[w_addr[OFF +: IDXW]][i*8 +: 8] <= bus.w_data[i*8 +: 8];
            end
        end
    end

    assign bus.aw_ready = rst_n && (w_state == W_IDLE);
    assign bus.w_ready  = (w_state == W_DATA);
    assign bus.b_valid  = (w_state == W_RESP);
    assign bus.b_resp   = ((w_state == W_RESP) && w_err) ? 2'b10 : 2'b00;
    assign bus.b_id     = b_id_q;
    assign bus.b_user   = b_user_q;

    logic unused_sideband;
    assign unused_sideband = ^{bus.aw_size, bus.aw_snoop, bus.ar_size, bus.ar_snoop};
endmodule
